// File: rtl/ret_addr_stack_pkg.sv
// Shared constants for the return-address stack and the PC-select mux it feeds.
package ret_addr_stack_pkg;

    localparam int PC_W          = 10;
    localparam int DEFAULT_DEPTH = 32;

    // PC-select mux encodings; the stack output drives input PCSEL_STACK.
    typedef enum logic [1:0] {
        PCSEL_IR    = 2'b00,
        PCSEL_STACK = 2'b01,
        PCSEL_VEC   = 2'b10,
        PCSEL_ZERO  = 2'b11
    } pc_sel_e;

endpackage

// File: rtl/ret_addr_stack_mem.sv
// Return-address storage: one write port, two asynchronous read ports, no reset.
module ras_mem
    import ret_addr_stack_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int AW    = PC_W,
    parameter int IW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [IW-1:0] wr_idx,
    input  logic [AW-1:0] wr_data,
    input  logic [IW-1:0] rd0_idx,
    output logic [AW-1:0] rd0_data,
    input  logic [IW-1:0] rd1_idx,
    output logic [AW-1:0] rd1_data
);

    logic [AW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end

    assign rd0_data = mem[rd0_idx];
    assign rd1_data = mem[rd1_idx];

endmodule

// File: rtl/ret_addr_stack.sv
// Hardware return-address stack: COUNT register, registered top-of-stack and sticky error flags.
module ret_addr_stack
    import ret_addr_stack_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int AW    = PC_W
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic [AW-1:0]              pc_in,
    input  logic                       clr_err,
    output logic [AW-1:0]              from_stack,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty,
    output logic                       ovf,
    output logic                       unf
);

    localparam int IW = $clog2(DEPTH);
    localparam int CW = IW + 1;

    logic [CW-1:0] count_reg, count_next;
    logic [AW-1:0] top_reg, top_next;
    logic          ovf_reg, ovf_next;
    logic          unf_reg, unf_next;
    logic          ovf_ev, unf_ev;

    logic          wr_en;
    logic [IW-1:0] wr_idx;
    logic [AW-1:0] ret_addr;
    logic [IW-1:0] top_idx, below_idx;
    logic [AW-1:0] rd_top, rd_below;
    logic          is_empty, is_full;

    assign ret_addr  = pc_in + AW'(1);
    assign is_empty  = (count_reg == '0);
    assign is_full   = (count_reg == CW'(DEPTH));
    assign top_idx   = IW'(count_reg - CW'(1));
    assign below_idx = IW'(count_reg - CW'(2));

    // Writes are suppressed while reset is held so an interrupted push leaves storage alone.
    ras_mem #(.DEPTH(DEPTH), .AW(AW), .IW(IW)) u_mem (
        .clk      (clk),
        .wr_en    (wr_en & rst_n),
        .wr_idx   (wr_idx),
        .wr_data  (ret_addr),
        .rd0_idx  (top_idx),
        .rd0_data (rd_top),
        .rd1_idx  (below_idx),
        .rd1_data (rd_below)
    );

    always_comb begin
        count_next = count_reg;
        top_next   = is_empty ? '0 : rd_top;
        wr_en      = 1'b0;
        wr_idx     = IW'(count_reg);
        ovf_ev     = 1'b0;
        unf_ev     = 1'b0;
        unique case ({push, pop})
            2'b10: begin
                if (is_full) begin
                    ovf_ev = 1'b1;
                end else begin
                    wr_en      = 1'b1;
                    count_next = count_reg + CW'(1);
                    top_next   = ret_addr;
                end
            end
            2'b01: begin
                if (is_empty) begin
                    unf_ev = 1'b1;
                end else if (count_reg == CW'(1)) begin
                    count_next = '0;
                    top_next   = '0;
                end else begin
                    count_next = count_reg - CW'(1);
                    top_next   = rd_below;
                end
            end
            2'b11: begin
                // Simultaneous CALL/RET replaces the top; on an empty stack it degrades to a push.
                wr_en    = 1'b1;
                top_next = ret_addr;
                if (is_empty) begin
                    wr_idx     = '0;
                    count_next = CW'(1);
                    unf_ev     = 1'b1;
                end else begin
                    wr_idx = top_idx;
                end
            end
            default: ;
        endcase
        ovf_next = ovf_ev | (ovf_reg & ~clr_err);
        unf_next = unf_ev | (unf_reg & ~clr_err);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
            top_reg   <= '0;
            ovf_reg   <= 1'b0;
            unf_reg   <= 1'b0;
        end else begin
            count_reg <= count_next;
            top_reg   <= top_next;
            ovf_reg   <= ovf_next;
            unf_reg   <= unf_next;
        end
    end

    assign from_stack = top_reg;
    assign count      = count_reg;
    assign full       = is_full;
    assign empty      = is_empty;
    assign ovf        = ovf_reg;
    assign unf        = unf_reg;

endmodule

// File: tb/tb_ret_addr_stack.sv
// Directed and randomized checks of ret_addr_stack against a queue-based stack model.
module tb_ret_addr_stack;

    localparam int DEPTH = 32;
    localparam int AW    = 10;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          push, pop, clr_err;
    logic [AW-1:0] pc_in;
    logic [AW-1:0] from_stack;
    logic [5:0]    count;
    logic          full, empty, ovf, unf;

    int checks = 0;
    int errors = 0;

    int m_stack[$];
    bit m_ovf, m_unf;

    ret_addr_stack #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push),
        .pop        (pop),
        .pc_in      (pc_in),
        .clr_err    (clr_err),
        .from_stack (from_stack),
        .count      (count),
        .full       (full),
        .empty      (empty),
        .ovf        (ovf),
        .unf        (unf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        int top;
        top = (m_stack.size() == 0) ? 0 : m_stack[$];
        chk({tag, ".count"}, 32'(count), 32'(m_stack.size()));
        chk({tag, ".from_stack"}, 32'(from_stack), 32'(top));
        chk({tag, ".full"}, 32'(full), 32'(m_stack.size() == DEPTH));
        chk({tag, ".empty"}, 32'(empty), 32'(m_stack.size() == 0));
        chk({tag, ".ovf"}, 32'(ovf), 32'(m_ovf));
        chk({tag, ".unf"}, 32'(unf), 32'(m_unf));
    endtask

    // Stack semantics stated directly on a queue: back of queue is the top of stack.
    task automatic model_step(input bit p, input bit q, input int pc, input bit c);
        int  ra;
        bit  o_ev, u_ev;
        ra   = (pc + 1) % (1 << AW);
        o_ev = 0;
        u_ev = 0;
        if (p && q) begin
            if (m_stack.size() == 0) begin
                m_stack.push_back(ra);
                u_ev = 1;
            end else begin
                m_stack[m_stack.size() - 1] = ra;
            end
        end else if (p) begin
            if (m_stack.size() == DEPTH) o_ev = 1;
            else m_stack.push_back(ra);
        end else if (q) begin
            if (m_stack.size() == 0) u_ev = 1;
            else void'(m_stack.pop_back());
        end
        m_ovf = o_ev || (m_ovf && !c);
        m_unf = u_ev || (m_unf && !c);
    endtask

    task automatic cycle(input string tag, input bit p, input bit q, input int pc, input bit c);
        push    = p;
        pop     = q;
        pc_in   = AW'(pc);
        clr_err = c;
        @(posedge clk);
        #1;
        push    = 1'b0;
        pop     = 1'b0;
        clr_err = 1'b0;
        model_step(p, q, pc, c);
        $display("%s push=%0b pop=%0b pc=%03h clr=%0b -> count=%0d top=%03h ovf=%0b unf=%0b",
                 tag, p, q, pc, c, count, from_stack, ovf, unf);
        check_all(tag);
    endtask

    initial begin
        int pct;
        rst_n   = 1'b0;
        push    = 1'b0;
        pop     = 1'b0;
        clr_err = 1'b0;
        pc_in   = '0;
        m_ovf   = 0;
        m_unf   = 0;
        #3;
        check_all("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single push, then drain.
        cycle("push010", 1, 0, 'h010, 0);
        chk("push010.top_const", 32'(from_stack), 32'h011);
        cycle("pop1", 0, 1, 0, 0);

        // LIFO ordering.
        cycle("p100", 1, 0, 'h100, 0);
        cycle("p200", 1, 0, 'h200, 0);
        cycle("p300", 1, 0, 'h300, 0);
        chk("lifo.top0", 32'(from_stack), 32'h301);
        cycle("pop_a", 0, 1, 0, 0);
        chk("lifo.top1", 32'(from_stack), 32'h201);
        cycle("pop_b", 0, 1, 0, 0);
        chk("lifo.top2", 32'(from_stack), 32'h101);
        cycle("pop_c", 0, 1, 0, 0);
        chk("lifo.top3", 32'(from_stack), 32'h000);

        // Fill, overflow, clear.
        for (int i = 0; i < DEPTH; i++) cycle("fill", 1, 0, 'h200 + i * 3, 0);
        cycle("ovf_push", 1, 0, 'h055, 0);
        chk("ovf.flag", 32'(ovf), 32'h1);
        cycle("ovf_hold", 0, 0, 0, 0);
        cycle("ovf_clr", 0, 0, 0, 1);
        cycle("full_repl", 1, 1, 'h123, 0);
        for (int i = 0; i < DEPTH; i++) cycle("drain", 0, 1, 0, 0);

        // Underflow and simultaneous push/pop when empty with wrap.
        cycle("unf_pop", 0, 1, 0, 0);
        chk("unf.flag", 32'(unf), 32'h1);
        cycle("clr_vs_ev", 0, 1, 0, 1);
        cycle("pp_empty", 1, 1, 'h3FF, 0);
        chk("pp_empty.count", 32'(count), 32'h1);
        cycle("pop2", 0, 1, 0, 1);

        // Replace top at COUNT=2, then expose the entry beneath.
        cycle("p010", 1, 0, 'h010, 0);
        cycle("p020", 1, 0, 'h020, 0);
        cycle("pp040", 1, 1, 'h040, 0);
        chk("repl.top", 32'(from_stack), 32'h041);
        cycle("pop_repl", 0, 1, 0, 0);
        chk("repl.below", 32'(from_stack), 32'h011);

        // Randomized traffic, alternating push-heavy and pop-heavy phases.
        for (int i = 0; i < 600; i++) begin
            pct = ((i / 75) % 2 == 0) ? 75 : 30;
            cycle("rnd", $urandom_range(0, 99) < pct, $urandom_range(0, 99) < (100 - pct),
                  int'($urandom_range(0, 1023)), $urandom_range(0, 9) == 0);
        end

        // Asynchronous reset pulse between edges with COUNT=5.
        while (m_stack.size() > 0) cycle("pre_rst", 0, 1, 0, 0);
        for (int i = 0; i < 5; i++) cycle("to5", 1, 0, 'h0A0 + i, 0);
        #1;
        rst_n = 1'b0;
        #1;
        m_stack.delete();
        m_ovf = 0;
        m_unf = 0;
        check_all("async_rst");
        #1;
        rst_n = 1'b1;
        cycle("post_rst", 1, 0, 'h1FE, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ret_addr_stack.md
RET_ADDR_STACK -- requirements
Module: ret_addr_stack

Interface
REQ-001 Parameter DEPTH, default 32: number of return-address entries; power of two, 4..64.
REQ-002 Parameter AW, default 10: address width; matches the 10-bit PC.
REQ-003 CLK  input  1: single clock; all state changes on its rising edge.
REQ-004 RST_N  input  1: reset; asynchronous assertion and deassertion, active-low.
REQ-005 PUSH  input  1: CALL executing; store the return address this cycle.
REQ-006 POP  input  1: RET/RETIE executing; discard the top entry this cycle.
REQ-007 PC_IN  input  AW: current PC of the CALL instruction.
REQ-008 CLR_ERR  input  1: synchronous clear of the sticky error flags.
REQ-009 FROM_STACK  output  AW: current top-of-stack return address; drives the PC-select mux input 2'b01.
REQ-010 COUNT  output  $clog2(DEPTH)+1: number of valid entries.
REQ-011 FULL  output  1: COUNT == DEPTH.
REQ-012 EMPTY  output  1: COUNT == 0.
REQ-013 OVF  output  1: sticky; a push was attempted while full.
REQ-014 UNF  output  1: sticky; a pop was attempted while empty.

Function
REQ-015 A push writes PC_IN+1 modulo 2^AW; 10'h3FF wraps to 10'h000.
REQ-016 FROM_STACK is a registered top-of-stack value, valid the cycle after the push/pop edge; zero latency from the storage array.
REQ-017 FROM_STACK is 0 whenever EMPTY is 1.
REQ-018 PUSH only, not full: the entry is written at index COUNT, COUNT increments, and FROM_STACK becomes PC_IN+1.
REQ-019 POP only, COUNT > 1: COUNT decrements and FROM_STACK becomes the entry at index COUNT-2.
REQ-020 POP only, COUNT == 1: COUNT becomes 0 and FROM_STACK becomes 0.
REQ-021 PUSH while FULL, POP not asserted: no storage change, COUNT unchanged, OVF set.
REQ-022 POP while EMPTY, PUSH not asserted: no change, UNF set.
REQ-023 PUSH and POP together, COUNT > 0: the top entry is replaced by PC_IN+1, COUNT unchanged, no flag set; this applies when FULL as well.
REQ-024 PUSH and POP together, EMPTY: the push is performed, COUNT becomes 1, and UNF is set.
REQ-025 CLR_ERR clears OVF and UNF; an error event in the same cycle takes priority and the flag stays set.
REQ-026 FULL and EMPTY are combinational decodes of COUNT.
REQ-027 Storage beyond COUNT is don't-care and is never observable on FROM_STACK.

Reset
REQ-028 RST_N low forces COUNT=0, FROM_STACK=0, OVF=0, UNF=0, FULL=0, EMPTY=1, immediately and without a clock.
REQ-029 Reset asserted mid-push or mid-pop abandons the operation; the storage array is not reset.
REQ-030 The first edge after RST_N rises may perform a push or pop.

Structure
REQ-031 The shared package holds the PC width constant (10), the default depth, and the PC-mux select encodings (00 IR, 01 stack, 10 0x3FF, 11 0x000) as an enum typedef.
REQ-032 One sub-module, ras_mem: a DEPTH x AW single-write-port register array with two asynchronous read ports (index COUNT-1 and COUNT-2); no reset on the array.
REQ-033 Pointer and flag logic lives in ret_addr_stack; no state machine beyond the COUNT register.

Verification
REQ-034 Reset, then PUSH with PC_IN=0x010 -> next cycle FROM_STACK=0x011, COUNT=1, EMPTY=0.
REQ-035 Push 0x100, 0x200, 0x300, then 3 pops -> FROM_STACK goes 0x301, then 0x201, then 0x101, then 0x000 with EMPTY=1.
REQ-036 Fill to 32 entries, then PUSH PC_IN=0x055 -> COUNT=32, top unchanged, OVF=1; CLR_ERR -> OVF=0.
REQ-037 POP when empty -> UNF=1, COUNT=0; PUSH+POP together when empty with PC_IN=0x3FF -> FROM_STACK=0x000, COUNT=1, UNF=1.
REQ-038 COUNT=2 with top 0x021, PUSH+POP with PC_IN=0x040 -> FROM_STACK=0x041, COUNT=2; POP -> FROM_STACK equals the first entry.
REQ-039 RST_N pulsed low between clock edges while COUNT=5 -> COUNT=0 and FROM_STACK=0 before the next edge.
